// File: rtl/isqrt_iterative_responder_if.sv
// Argument/result handshake between a sqrt formula FSM and the isqrt responder.
interface isqrt_iterative_responder_if #(
  parameter int n = 32
);
  logic           x_vld;
  logic [n-1:0]   x;
  logic           x_rdy;
  logic           y_vld;
  logic [n/2-1:0] y;
  logic           ovf;

  modport master (output x_vld, output x, input x_rdy, input y_vld, input y, input ovf);
  modport slave  (input x_vld, input x, output x_rdy, output y_vld, output y, output ovf);
endinterface

// File: rtl/isqrt_iterative_responder.sv
// Iterative integer square root, one result bit per cycle, fed by a small argument FIFO.
// state | meaning
// IDLE  | no operand in flight, waiting for the FIFO to hold an argument
// CALC  | one restoring root step per cycle, n/2 steps total
// DONE  | y holds the new root, y_vld high; next argument may load here
module isqrt_iterative_responder #(
  parameter int n     = 32,
  parameter int depth = 4
) (
  input  logic clk,
  input  logic rst,
  isqrt_iterative_responder_if.slave bus
);

  localparam int H  = n / 2;
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  logic [n-1:0]  mem_q [depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          full, empty, push, pop;

  state_t        state_q, state_d;
  logic [H+1:0]  rem_q, rem_d;
  logic [H-1:0]  root_q, root_d;
  logic [n-1:0]  op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [H-1:0]  y_q, y_d;

  logic [H+3:0]  rem_sh;
  logic [H+3:0]  trial;
  logic          ge;
  logic [H-1:0]  root_nx;

  // x_rdy looks only at the registered count, so a same-cycle pop never frees a slot early
  assign full  = (count_q == (AW+1)'(depth));
  assign empty = (count_q == '0);
  assign push  = bus.x_vld & ~full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.x_vld && full) ovf_q <= 1'b1;
    end
  end

  assign rem_sh  = {rem_q, op_q[n-1:n-2]};
  assign trial   = {2'b00, root_q, 2'b01};
  assign ge      = (rem_sh >= trial);
  assign root_nx = {root_q[H-2:0], ge};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    root_d  = root_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    pop     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (!empty) begin
          pop     = 1'b1;
          rem_d   = '0;
          root_d  = '0;
          op_d    = mem_q[rd_ptr_q];
          cnt_d   = CW'(H - 1);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d  = (H+2)'(ge ? (rem_sh - trial) : rem_sh);
        root_d = root_nx;
        op_d   = {op_q[n-3:0], 2'b00};
        if (cnt_q == '0) begin
          y_d     = root_nx;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      root_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign bus.x_rdy = ~full;
  assign bus.y_vld = (state_q == DONE);
  assign bus.y     = y_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_isqrt_iterative_responder.sv
// Bench for isqrt_iterative_responder: queue scoreboard fed by a binary-search sqrt model.
module tb_isqrt_iterative_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  isqrt_iterative_responder_if #(.n(32)) bus ();

  isqrt_iterative_responder #(.n(32), .depth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_vld = 0;
  int vld_cyc = 0;
  bit prev_vld = 1'b0;
  logic [15:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_sqrt(input longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every y_vld pulse consumes exactly one expected result
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.y_vld) begin
        n_vld++;
        vld_cyc = cyc;
        n_chk++;
        if (prev_vld) begin
          n_bad++;
          $display("FAIL y_vld_consecutive: got 1 expected 0 (cycle %0d)", cyc);
        end
        n_chk++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_y_vld: got y=%0d expected no pulse (cycle %0d)", bus.y, cyc);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.y !== e) begin
            n_bad++;
            $display("FAIL y_value: got %0d expected %0d (cycle %0d)", bus.y, e, cyc);
          end
        end
      end
      prev_vld = bus.y_vld;
    end else begin
      prev_vld = 1'b0;
    end
  end

  // Called at negedge+1; leaves x_vld asserted for the caller to clear.
  task automatic drive(input logic [31:0] v, output bit acc, output int e0);
    bus.x_vld = 1'b1;
    bus.x     = v;
    acc       = bus.x_rdy;
    e0        = cyc + 1;
    if (acc) exp_q.push_back(ref_sqrt(v));
    @(negedge clk); #1;
  endtask

  task automatic wait_one(input string name, output int c);
    int n0;
    bit seen;
    n0   = n_vld;
    seen = 1'b0;
    c    = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk); #1;
      if (n_vld != n0) begin
        seen = 1'b1;
        c    = vld_cyc;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic single(input logic [31:0] v);
    bit acc;
    int e0, c;
    drive(v, acc, e0);
    bus.x_vld = 1'b0;
    chk("single_accepted", acc, 1);
    wait_one("single", c);
    chk("single_latency", c - e0, 17);
  endtask

  initial begin
    bit acc;
    int e0, c1, c2, c3, nacc, sent, guard, burst, nv0;
    logic [31:0] v;
    logic [15:0] r;
    logic [31:0] singles [6];
    singles = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd1000000, 32'hFFFF_FFFF};

    bus.x_vld = 1'b0;
    bus.x     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_y_vld", bus.y_vld, 0);
    chk("reset_y", bus.y, 0);
    chk("reset_ovf", bus.ovf, 0);
    chk("reset_x_rdy", bus.x_rdy, 1);

    foreach (singles[i]) single(singles[i]);
    chk("singles_ovf", bus.ovf, 0);

    // back-to-back 4, 9, 144
    drive(32'd4, acc, e0);   chk("b2b_rdy0", acc, 1);
    drive(32'd9, acc, c1);   chk("b2b_rdy1", acc, 1);
    drive(32'd144, acc, c1); chk("b2b_rdy2", acc, 1);
    bus.x_vld = 1'b0;
    wait_one("b2b0", c1);
    wait_one("b2b1", c2);
    wait_one("b2b2", c3);
    chk("b2b_lat0", c1 - e0, 17);
    chk("b2b_gap1", c2 - c1, 17);
    chk("b2b_gap2", c3 - c2, 17);

    // chained: c=16, then b+sqrt(c), then a+that
    r = ref_sqrt(16);
    single(32'd16);
    @(negedge clk); #1;
    v = 32'd21 + r;
    r = ref_sqrt(v);
    single(v);
    @(negedge clk); #1;
    single(32'd44 + r);
    chk("chain_model", r, 5);

    // overflow: six consecutive pushes into a 4-deep FIFO
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("ovf_x_rdy_before_6th", bus.x_rdy, 0);
      drive(32'd100 + 32'(i), acc, e0);
      if (acc) nacc++;
    end
    bus.x_vld = 1'b0;
    chk("ovf_accepted", nacc, 5);
    chk("ovf_set", bus.ovf, 1);
    for (int i = 0; i < 5; i++) wait_one("ovf_result", c1);
    repeat (20) @(negedge clk);
    #1;
    chk("ovf_sticky", bus.ovf, 1);
    chk("ovf_queue_drained", exp_q.size(), 0);

    // reset mid-calculation
    drive(32'd1000, acc, e0);
    drive(32'd2000, acc, e0);
    drive(32'd3000, acc, e0);
    bus.x_vld = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_y", bus.y, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_x_rdy", bus.x_rdy, 1);
    chk("rst_y_vld", bus.y_vld, 0);
    nv0 = n_vld;
    repeat (60) @(negedge clk);
    #1;
    chk("rst_no_pulses", n_vld - nv0, 0);
    single(32'd49);

    // random regression, never pushing while full
    sent  = 0;
    guard = 0;
    burst = 0;
    while (sent < 1000 && guard < 40000) begin
      guard++;
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(2, 4);
      if ((burst > 0 || $urandom_range(0, 15) == 0) && bus.x_rdy) begin
        case ($urandom_range(0, 7))
          0: begin v = $urandom_range(0, 65535); v = v * v; end
          1: begin v = $urandom_range(1, 65535); v = v * v - 1; end
          2: v = $urandom_range(0, 300);
          default: v = $urandom;
        endcase
        bus.x_vld = 1'b1;
        bus.x     = v;
        exp_q.push_back(ref_sqrt(v));
        sent++;
        if (burst > 0) burst--;
      end else begin
        bus.x_vld = 1'b0;
      end
      @(negedge clk); #1;
    end
    bus.x_vld = 1'b0;
    chk("rand_all_sent", sent, 1000);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      guard++;
      @(negedge clk); #1;
    end
    repeat (40) @(negedge clk);
    #1;
    chk("rand_queue_drained", exp_q.size(), 0);
    chk("rand_ovf", bus.ovf, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
